// File: rtl/pinmux_ctrl_pkg.sv
// Shared types for the pinmux select-switch controller: FSM states, port-stop
// safe-value encodings, default widths and a small helper.
package pinmux_ctrl_pkg;

    localparam int SEL_WIDTH_DEF     = 5;
    localparam int PES_WIDTH_DEF     = 8;
    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int CNT_WIDTH         = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_PES_HOLD = 2'd3
    } state_t;

    // 2'b11 is a second encoding of hi-Z.
    typedef enum logic [1:0] {
        SAFE_HIZ  = 2'b00,
        SAFE_LO   = 2'b01,
        SAFE_HI   = 2'b10,
        SAFE_HIZ2 = 2'b11
    } safeval_t;

    // True when the safe state actively drives the pad.
    function automatic logic safe_drives(input logic [1:0] sv);
        return (sv == SAFE_LO) || (sv == SAFE_HI);
    endfunction

endpackage

// File: rtl/pinmux_sel_switch_ctrl_if.sv
// Request and port-stop bundle between a pin-configuration master and the
// select-switch controller.
interface pinmux_sel_switch_ctrl_if #(
    parameter int SEL_WIDTH = 5,
    parameter int PES_WIDTH = 8
);
    logic                 i_req_valid;
    logic [SEL_WIDTH-1:0] i_req_sel;
    logic                 i_req_od;
    logic                 o_req_ready;
    logic [PES_WIDTH-1:0] i_pes_err;
    logic [PES_WIDTH-1:0] i_pes_en;
    logic [1:0]           i_pes_safeval;
    logic                 i_pes_clr;
    logic [SEL_WIDTH-1:0] o_outfunc_sel;
    logic                 o_pinctlx_od;
    logic                 o_gpioquten;
    logic                 o_pes_force;
    logic                 o_pes_value;
    logic                 o_busy;
    logic [PES_WIDTH-1:0] o_pes_log;

    modport slave (
        input  i_req_valid, i_req_sel, i_req_od,
        input  i_pes_err, i_pes_en, i_pes_safeval, i_pes_clr,
        output o_req_ready, o_outfunc_sel, o_pinctlx_od, o_gpioquten,
        output o_pes_force, o_pes_value, o_busy, o_pes_log
    );

    modport master (
        output i_req_valid, i_req_sel, i_req_od,
        output i_pes_err, i_pes_en, i_pes_safeval, i_pes_clr,
        input  o_req_ready, o_outfunc_sel, o_pinctlx_od, o_gpioquten,
        input  o_pes_force, o_pes_value, o_busy, o_pes_log
    );

endinterface

// File: rtl/pinmux_settle_cnt.sv
// Tri-state settle down-counter: reloads to SETTLE_CYCLES-1, decrements on
// request and saturates at zero.
module pinmux_settle_cnt
    import pinmux_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= RELOAD;
        end else if (load) begin
            cnt_reg <= RELOAD;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/pinmux_sel_switch_ctrl.sv
// Pinmux select-switch controller: gates the pad off, waits for the tri-state
// to settle, swaps the output function, re-enables; port-stop overrides all.
// Optional sticky cause log is compiled in with PINMUX_SWCTRL_PES_LOG_EN.
module pinmux_sel_switch_ctrl
    import pinmux_ctrl_pkg::*;
#(
    parameter int SEL_WIDTH     = SEL_WIDTH_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int PES_WIDTH     = PES_WIDTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    pinmux_sel_switch_ctrl_if.slave  bus
);

    state_t               state_reg,   state_next;
    logic [SEL_WIDTH-1:0] sel_reg,     sel_next;
    logic                 od_reg,      od_next;
    logic [SEL_WIDTH-1:0] tgt_sel_reg, tgt_sel_next;
    logic                 tgt_od_reg,  tgt_od_next;
    logic                 quten_reg,   quten_next;
    logic                 force_reg,   force_next;
    logic                 value_reg,   value_next;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic pes_hit;
    logic req_ready;
    logic req_same;
    logic clr_fire;

    pinmux_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    assign pes_hit   = |(bus.i_pes_err & bus.i_pes_en);
    assign req_ready = (state_reg == ST_IDLE) && !pes_hit;
    assign req_same  = (bus.i_req_sel == sel_reg) && (bus.i_req_od == od_reg);
    assign clr_fire  = (state_reg == ST_PES_HOLD) && bus.i_pes_clr && !pes_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_SETTLE;
            sel_reg     <= '0;
            od_reg      <= 1'b0;
            tgt_sel_reg <= '0;
            tgt_od_reg  <= 1'b0;
            quten_reg   <= 1'b0;
            force_reg   <= 1'b0;
            value_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            od_reg      <= od_next;
            tgt_sel_reg <= tgt_sel_next;
            tgt_od_reg  <= tgt_od_next;
            quten_reg   <= quten_next;
            force_reg   <= force_next;
            value_reg   <= value_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        od_next      = od_reg;
        tgt_sel_next = tgt_sel_reg;
        tgt_od_next  = tgt_od_reg;
        quten_next   = quten_reg;
        force_next   = force_reg;
        value_next   = value_reg;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        if (pes_hit) begin
            // Port-stop pre-empts everything, including a switch about to land.
            state_next = ST_PES_HOLD;
            force_next = 1'b1;
            value_next = (bus.i_pes_safeval == SAFE_HI);
            quten_next = safe_drives(bus.i_pes_safeval);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_req_valid && !req_same) begin
                        tgt_sel_next = bus.i_req_sel;
                        tgt_od_next  = bus.i_req_od;
                        quten_next   = 1'b0;
                        cnt_load     = 1'b1;
                        state_next   = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        sel_next   = tgt_sel_reg;
                        od_next    = tgt_od_reg;
                        state_next = ST_SWITCH;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_SWITCH: begin
                    quten_next = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_PES_HOLD: begin
                    if (bus.i_pes_clr) begin
                        // Re-enter via a full settle so the pad comes back cleanly.
                        force_next   = 1'b0;
                        value_next   = 1'b0;
                        quten_next   = 1'b0;
                        tgt_sel_next = sel_reg;
                        tgt_od_next  = od_reg;
                        cnt_load     = 1'b1;
                        state_next   = ST_SETTLE;
                    end else begin
                        value_next = (bus.i_pes_safeval == SAFE_HI);
                        quten_next = safe_drives(bus.i_pes_safeval);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

`ifdef PINMUX_SWCTRL_PES_LOG_EN
    logic [PES_WIDTH-1:0] log_reg;

    for (genvar gi = 0; gi < PES_WIDTH; gi++) begin : g_log
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                log_reg[gi] <= 1'b0;
            end else if (clr_fire) begin
                log_reg[gi] <= 1'b0;
            end else if (bus.i_pes_err[gi] && bus.i_pes_en[gi]) begin
                log_reg[gi] <= 1'b1;
            end
        end
    end

    assign bus.o_pes_log = log_reg;
`else
    assign bus.o_pes_log = '0;
`endif

    assign bus.o_req_ready   = req_ready;
    assign bus.o_outfunc_sel = sel_reg;
    assign bus.o_pinctlx_od  = od_reg;
    assign bus.o_gpioquten   = quten_reg;
    assign bus.o_pes_force   = force_reg;
    assign bus.o_pes_value   = value_reg;
    assign bus.o_busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pinmux_sel_switch_ctrl.sv
// Bench for pinmux_sel_switch_ctrl: directed scenarios plus random traffic
// checked against a timestamp-based behavioural model.
module tb_pinmux_sel_switch_ctrl;

    localparam int S   = 4;
    localparam int SW  = 5;
    localparam int PW  = 8;

    logic clk;
    logic rst_n;

    pinmux_sel_switch_ctrl_if #(.SEL_WIDTH(SW), .PES_WIDTH(PW)) bus ();

    pinmux_sel_switch_ctrl #(
        .SEL_WIDTH     (SW),
        .SETTLE_CYCLES (S),
        .PES_WIDTH     (PW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Model: a switch accepted on edge k lands its select on edge k+S and
    // re-enables the pad on edge k+S+1; port-stop overrides and cancels it.
    int          cyc;
    bit          m_pend;
    bit          m_hold;
    int          t_sel;
    int          t_on;
    logic [SW-1:0] m_sel, p_sel;
    logic        m_od, p_od;
    logic        m_quten, m_force, m_value;
    logic [PW-1:0] m_log;

    task automatic model_reset();
        cyc = 0; m_pend = 1; m_hold = 0;
        p_sel = '0; p_od = 0; t_sel = S; t_on = S + 1;
        m_sel = '0; m_od = 0; m_quten = 0; m_force = 0; m_value = 0; m_log = '0;
    endtask

    task automatic model_edge();
        logic [PW-1:0] act;
        logic [1:0]    sv;
        act = bus.i_pes_err & bus.i_pes_en;
        sv  = bus.i_pes_safeval;
        cyc++;
        m_log = m_log | act;
        if (act != '0) begin
            m_hold = 1; m_pend = 0; m_force = 1;
            m_value = (sv == 2'b10);
            m_quten = (sv == 2'b01) || (sv == 2'b10);
        end else if (m_hold) begin
            if (bus.i_pes_clr) begin
                m_hold = 0; m_force = 0; m_value = 0; m_quten = 0; m_log = '0;
                m_pend = 1; p_sel = m_sel; p_od = m_od;
                t_sel = cyc + S; t_on = cyc + S + 1;
            end else begin
                m_value = (sv == 2'b10);
                m_quten = (sv == 2'b01) || (sv == 2'b10);
            end
        end else if (m_pend) begin
            if (cyc == t_sel) begin m_sel = p_sel; m_od = p_od; end
            if (cyc == t_on)  begin m_quten = 1; m_pend = 0; end
        end else if (bus.i_req_valid) begin
            if (bus.i_req_sel != m_sel || bus.i_req_od != m_od) begin
                m_pend = 1; p_sel = bus.i_req_sel; p_od = bus.i_req_od;
                t_sel = cyc + S; t_on = cyc + S + 1; m_quten = 0;
            end
        end
    endtask

    function automatic bit model_ready();
        return !m_hold && !m_pend && ((bus.i_pes_err & bus.i_pes_en) == '0);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_req_valid = 0; bus.i_req_sel = '0; bus.i_req_od = 0;
        bus.i_pes_err = '0; bus.i_pes_en = '0; bus.i_pes_safeval = 2'b00; bus.i_pes_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.o_outfunc_sel !== '0 || bus.o_pinctlx_od !== 0 || bus.o_gpioquten !== 0 ||
            bus.o_pes_force !== 0 || bus.o_pes_value !== 0 || bus.o_pes_log !== '0) begin
            bad++;
            $display("FAIL reset_outputs sel=%0h od=%b quten=%b force=%b value=%b log=%0h want all zero",
                     bus.o_outfunc_sel, bus.o_pinctlx_od, bus.o_gpioquten, bus.o_pes_force,
                     bus.o_pes_value, bus.o_pes_log);
        end
        total++;
        if (bus.o_busy !== 1 || bus.o_req_ready !== 0) begin
            bad++;
            $display("FAIL reset_busy busy=%b ready=%b want busy=1 ready=0", bus.o_busy, bus.o_req_ready);
        end
        rst_n = 1;
        model_reset();
        for (int e = 1; e <= 6; e++) begin
            step();
            total++;
            if (bus.o_gpioquten !== (e >= S + 1) || bus.o_outfunc_sel !== '0) begin
                bad++;
                $display("FAIL reset_release edge=%0d quten=%b sel=%0h want quten=%b sel=0",
                         e, bus.o_gpioquten, bus.o_outfunc_sel, (e >= S + 1));
            end
        end
        $display("reset release: quten=%b busy=%b", bus.o_gpioquten, bus.o_busy);
    endtask

    task automatic test_switch();
        bus.i_req_valid = 1; bus.i_req_sel = 5'd3; bus.i_req_od = 0;
        #1;
        total++;
        if (bus.o_req_ready !== 1) begin
            bad++; $display("FAIL switch_ready got=%b want=1", bus.o_req_ready);
        end
        step();
        bus.i_req_valid = 0;
        total++;
        if (bus.o_gpioquten !== 0 || bus.o_busy !== 1) begin
            bad++; $display("FAIL switch_accept quten=%b busy=%b want 0/1", bus.o_gpioquten, bus.o_busy);
        end
        for (int e = 1; e <= S + 1; e++) begin
            step();
            total++;
            if (bus.o_outfunc_sel !== ((e >= S) ? 5'd3 : 5'd0) || bus.o_gpioquten !== (e >= S + 1)) begin
                bad++;
                $display("FAIL switch_seq edge=%0d sel=%0d quten=%b want sel=%0d quten=%b",
                         e, bus.o_outfunc_sel, bus.o_gpioquten, (e >= S) ? 3 : 0, (e >= S + 1));
            end
        end
        $display("switch to sel=3: sel=%0d quten=%b", bus.o_outfunc_sel, bus.o_gpioquten);
    endtask

    task automatic test_noop();
        bus.i_req_valid = 1; bus.i_req_sel = 5'd3; bus.i_req_od = 0;
        #1;
        total++;
        if (bus.o_req_ready !== 1) begin
            bad++; $display("FAIL noop_ready got=%b want=1", bus.o_req_ready);
        end
        for (int e = 0; e < 3; e++) begin
            step();
            total++;
            if (bus.o_gpioquten !== 1 || bus.o_busy !== 0 || bus.o_outfunc_sel !== 5'd3) begin
                bad++;
                $display("FAIL noop_hold edge=%0d quten=%b busy=%b sel=%0d want 1/0/3",
                         e, bus.o_gpioquten, bus.o_busy, bus.o_outfunc_sel);
            end
        end
        bus.i_req_valid = 0;
        $display("noop request: busy=%b quten=%b", bus.o_busy, bus.o_gpioquten);
    endtask

    task automatic test_pes();
        bus.i_req_valid = 1; bus.i_req_sel = 5'd5; bus.i_req_od = 1;
        step();
        bus.i_req_valid = 0;
        step();
        bus.i_pes_err = 8'h04; bus.i_pes_en = 8'h04; bus.i_pes_safeval = 2'b10;
        for (int e = 0; e < S + 2; e++) begin
            step();
            total++;
            if (bus.o_pes_force !== 1 || bus.o_pes_value !== 1 || bus.o_gpioquten !== 1 ||
                bus.o_outfunc_sel !== 5'd3 || bus.o_pinctlx_od !== 0 || bus.o_busy !== 1) begin
                bad++;
                $display("FAIL pes_hold edge=%0d force=%b value=%b quten=%b sel=%0d od=%b busy=%b want 1/1/1/3/0/1",
                         e, bus.o_pes_force, bus.o_pes_value, bus.o_gpioquten, bus.o_outfunc_sel,
                         bus.o_pinctlx_od, bus.o_busy);
            end
`ifdef PINMUX_SWCTRL_PES_LOG_EN
            total++;
            if (bus.o_pes_log !== 8'h04) begin
                bad++; $display("FAIL pes_log got=%0h want=04", bus.o_pes_log);
            end
`endif
        end
        bus.i_pes_clr = 1;
        step();
        bus.i_pes_clr = 0;
        total++;
        if (bus.o_pes_force !== 1) begin
            bad++; $display("FAIL pes_clr_ignored force=%b want=1", bus.o_pes_force);
        end
        bus.i_pes_err = '0; bus.i_pes_en = '0; bus.i_pes_safeval = 2'b01;
        step();
        total++;
        if (bus.o_pes_force !== 1 || bus.o_gpioquten !== 1 || bus.o_pes_value !== 0) begin
            bad++;
            $display("FAIL pes_track force=%b quten=%b value=%b want 1/1/0",
                     bus.o_pes_force, bus.o_gpioquten, bus.o_pes_value);
        end
        bus.i_pes_clr = 1;
        step();
        bus.i_pes_clr = 0;
        total++;
        if (bus.o_pes_force !== 0 || bus.o_gpioquten !== 0 || bus.o_pes_log !== '0) begin
            bad++;
            $display("FAIL pes_release force=%b quten=%b log=%0h want 0/0/0",
                     bus.o_pes_force, bus.o_gpioquten, bus.o_pes_log);
        end
        for (int e = 1; e <= S + 1; e++) begin
            step();
            total++;
            if (bus.o_gpioquten !== (e >= S + 1) || bus.o_busy !== (e < S + 1) || bus.o_outfunc_sel !== 5'd3) begin
                bad++;
                $display("FAIL pes_resettle edge=%0d quten=%b busy=%b sel=%0d want %b/%b/3",
                         e, bus.o_gpioquten, bus.o_busy, bus.o_outfunc_sel, (e >= S + 1), (e < S + 1));
            end
        end
        $display("port-stop cycle done: force=%b quten=%b sel=%0d", bus.o_pes_force, bus.o_gpioquten, bus.o_outfunc_sel);
    endtask

    task automatic test_pes_vs_req();
        bus.i_req_valid = 1; bus.i_req_sel = 5'd9; bus.i_req_od = 0;
        bus.i_pes_err = 8'h01; bus.i_pes_en = 8'h01; bus.i_pes_safeval = 2'b00;
        #1;
        total++;
        if (bus.o_req_ready !== 0) begin
            bad++; $display("FAIL race_ready got=%b want=0", bus.o_req_ready);
        end
        step();
        idle_inputs();
        total++;
        if (bus.o_pes_force !== 1 || bus.o_gpioquten !== 0 || bus.o_outfunc_sel !== 5'd3) begin
            bad++;
            $display("FAIL race_hold force=%b quten=%b sel=%0d want 1/0/3",
                     bus.o_pes_force, bus.o_gpioquten, bus.o_outfunc_sel);
        end
        bus.i_pes_clr = 1;
        step();
        bus.i_pes_clr = 0;
        repeat (S + 1) step();
        total++;
        if (bus.o_outfunc_sel !== 5'd3 || bus.o_gpioquten !== 1 || bus.o_busy !== 0) begin
            bad++;
            $display("FAIL race_not_captured sel=%0d quten=%b busy=%b want 3/1/0",
                     bus.o_outfunc_sel, bus.o_gpioquten, bus.o_busy);
        end
        $display("pes vs request: sel=%0d", bus.o_outfunc_sel);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.i_req_valid   = 1'($urandom_range(0, 1));
            bus.i_req_sel     = SW'($urandom_range(0, 3));
            bus.i_req_od      = 1'($urandom_range(0, 1));
            bus.i_pes_en      = PW'($urandom);
            bus.i_pes_err     = ($urandom_range(0, 19) == 0) ? PW'(1 << $urandom_range(0, PW - 1)) : '0;
            bus.i_pes_safeval = 2'($urandom_range(0, 3));
            bus.i_pes_clr     = ($urandom_range(0, 3) == 0);
            #1;
            total++;
            if (bus.o_req_ready !== model_ready()) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, bus.o_req_ready, model_ready());
            end
            step();
            total++;
            if (bus.o_outfunc_sel !== m_sel || bus.o_pinctlx_od !== m_od) begin
                bad++;
                $display("FAIL rnd_select cyc=%0d sel=%0d od=%b want %0d/%b", cyc, bus.o_outfunc_sel,
                         bus.o_pinctlx_od, m_sel, m_od);
            end
            total++;
            if (bus.o_gpioquten !== m_quten || bus.o_busy !== (m_hold || m_pend)) begin
                bad++;
                $display("FAIL rnd_quten cyc=%0d quten=%b busy=%b want %b/%b", cyc, bus.o_gpioquten,
                         bus.o_busy, m_quten, (m_hold || m_pend));
            end
            total++;
            if (bus.o_pes_force !== m_force || bus.o_pes_value !== m_value) begin
                bad++;
                $display("FAIL rnd_force cyc=%0d force=%b value=%b want %b/%b", cyc, bus.o_pes_force,
                         bus.o_pes_value, m_force, m_value);
            end
            total++;
`ifdef PINMUX_SWCTRL_PES_LOG_EN
            if (bus.o_pes_log !== m_log) begin
                bad++; $display("FAIL rnd_log cyc=%0d got=%0h want=%0h", cyc, bus.o_pes_log, m_log);
            end
`else
            if (bus.o_pes_log !== '0) begin
                bad++; $display("FAIL rnd_log cyc=%0d got=%0h want=0", cyc, bus.o_pes_log);
            end
`endif
        end
        idle_inputs();
        $display("random traffic: %0d cycles, sel=%0d", 1500, bus.o_outfunc_sel);
    endtask

    task automatic test_reset_mid();
        bus.i_pes_err = 8'h80; bus.i_pes_en = 8'h80; bus.i_pes_safeval = 2'b10;
        step();
        #3;
        rst_n = 0;
        #1;
        total++;
        if (bus.o_pes_force !== 0 || bus.o_pes_value !== 0 || bus.o_gpioquten !== 0 ||
            bus.o_outfunc_sel !== '0 || bus.o_pinctlx_od !== 0 || bus.o_pes_log !== '0 || bus.o_busy !== 1) begin
            bad++;
            $display("FAIL reset_mid force=%b value=%b quten=%b sel=%0d od=%b log=%0h busy=%b want 0s busy=1",
                     bus.o_pes_force, bus.o_pes_value, bus.o_gpioquten, bus.o_outfunc_sel,
                     bus.o_pinctlx_od, bus.o_pes_log, bus.o_busy);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        model_reset();
        repeat (S + 1) step();
        total++;
        if (bus.o_gpioquten !== 1 || bus.o_busy !== 0 || bus.o_outfunc_sel !== '0) begin
            bad++;
            $display("FAIL reset_mid_recover quten=%b busy=%b sel=%0d want 1/0/0",
                     bus.o_gpioquten, bus.o_busy, bus.o_outfunc_sel);
        end
        $display("mid-hold reset: quten=%b", bus.o_gpioquten);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_switch();
        test_noop();
        test_pes();
        test_pes_vs_req();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pinmux_sel_switch_ctrl.md
PINMUX_SEL_SWITCH_CTRL -- requirements
Module: pinmux_sel_switch_ctrl

Interface
REQ-001 Parameter SEL_WIDTH, default 5, SHALL set the width of the output-function select.
REQ-002 Parameter SETTLE_CYCLES, default 4, legal range 1..255, SHALL set the tri-state settle time in clock cycles.
REQ-003 Parameter PES_WIDTH, default 8, SHALL set the number of port-stop error sources.
REQ-004 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req_valid  in  1  new pin configuration request.
REQ-007 i_req_sel  in  SEL_WIDTH  requested output-function select.
REQ-008 i_req_od  in  1  requested open-drain enable.
REQ-009 o_req_ready  out  1  request accepted when valid and ready are both high on the same edge.
REQ-010 i_pes_err  in  PES_WIDTH  port-stop error sources, level.
REQ-011 i_pes_en  in  PES_WIDTH  per-source port-stop enable.
REQ-012 i_pes_safeval  in  2  safe state: 00 hi-Z, 01 drive 0, 10 drive 1, 11 hi-Z.
REQ-013 i_pes_clr  in  1  single-cycle pulse releasing port-stop.
REQ-014 o_outfunc_sel  out  SEL_WIDTH  registered select to the pinmux output mux.
REQ-015 o_pinctlx_od  out  1  registered open-drain control.
REQ-016 o_gpioquten  out  1  registered pad output-enable gate.
REQ-017 o_pes_force  out  1  registered; high while in PES_HOLD.
REQ-018 o_pes_value  out  1  registered forced pad data (1 only for safeval 10).
REQ-019 o_busy  out  1  high whenever state is not IDLE.
REQ-020 o_pes_log  out  PES_WIDTH  sticky port-stop cause (see REQ-036).

Function
REQ-021 The FSM SHALL have the states IDLE, SETTLE, SWITCH and PES_HOLD.
REQ-022 pes_hit SHALL be defined as |(i_pes_err & i_pes_en); o_req_ready SHALL equal (state==IDLE) & ~pes_hit, combinationally.
REQ-023 IDLE, accepted request with sel/od equal to current outputs: the FSM SHALL remain in IDLE with no change to o_gpioquten (no-op acknowledge).
REQ-024 IDLE, accepted request that differs from current outputs: the FSM SHALL capture sel/od, clear o_gpioquten, load the counter with SETTLE_CYCLES-1 and enter SETTLE on the same edge.
REQ-025 SETTLE: the FSM SHALL decrement the counter each edge; with the counter at 0, the next edge SHALL enter SWITCH and update o_outfunc_sel/o_pinctlx_od from the captured values.
REQ-026 SWITCH: the next edge SHALL set o_gpioquten=1 and return to IDLE.
REQ-027 Latency: o_outfunc_sel SHALL change SETTLE_CYCLES edges after acceptance; o_gpioquten SHALL be low for exactly SETTLE_CYCLES+1 cycles.
REQ-028 pes_hit in any state SHALL, on the next edge, enter PES_HOLD, set o_pes_force=1, set o_pes_value=(safeval==10), set o_gpioquten=(safeval==01 or 10), and abort any in-flight switch without updating select/od.
REQ-029 PES_HOLD SHALL track i_pes_safeval every cycle and ignore requests.
REQ-030 PES_HOLD with i_pes_clr=1 and pes_hit=0 SHALL clear o_pes_force, clear o_gpioquten and enter SETTLE (counter SETTLE_CYCLES-1) targeting the current select/od; i_pes_clr with pes_hit=1 SHALL be ignored.
REQ-031 pes_hit and an accepted-looking request on the same edge: port-stop SHALL win and the request SHALL not be accepted.

Reset
REQ-032 While i_rst_n is low: state SETTLE, counter SETTLE_CYCLES-1, o_outfunc_sel=0, o_pinctlx_od=0, o_gpioquten=0, o_pes_force=0, o_pes_value=0, o_pes_log=0.
REQ-033 After reset release, the FSM SHALL reach IDLE with o_gpioquten=1 after SETTLE_CYCLES+1 edges, unless pes_hit is active.
REQ-034 Reset asserted mid-sequence or in PES_HOLD SHALL immediately return every output to its REQ-032 value.

Configuration
REQ-035 Macro PINMUX_SWCTRL_PES_LOG_EN SHALL select whether the cause log is compiled in.
REQ-036 With PINMUX_SWCTRL_PES_LOG_EN defined: o_pes_log SHALL OR in (i_pes_err & i_pes_en) every edge and clear on an i_pes_clr accepted per REQ-030. Without it: o_pes_log SHALL be constant 0 and no log flops SHALL exist.

Structure
REQ-037 Package pinmux_ctrl_pkg SHALL hold the FSM state enum, the safeval encodings (SAFE_HIZ, SAFE_LO, SAFE_HI) and the SEL_WIDTH default.
REQ-038 The settle counter SHALL be a sub-module pinmux_settle_cnt (load, decrement, zero flag).

Verification
REQ-039 Reset release, SETTLE_CYCLES=4, no pes -> o_gpioquten rises on the 5th edge, o_outfunc_sel=0.
REQ-040 Request sel=3 in IDLE -> quten low 5 cycles, sel=3 on the 4th edge after acceptance, quten=1 one edge later.
REQ-041 Request sel equal to current -> ready high, no quten dip, o_busy stays 0.
REQ-042 i_pes_err[2]=1, i_pes_en[2]=1 during SETTLE, safeval=10 -> PES_HOLD, force=1, value=1, quten=1, select unchanged, log=0x04 when the macro is defined.
REQ-043 i_pes_clr with err still high -> stays in PES_HOLD; drop err, then pulse clr -> settle sequence, IDLE after 5 edges, log cleared.
REQ-044 pes_hit and valid on the same edge in IDLE -> ready=0, request not captured.
